memory_stage: RTL and testbench

Y86-64 SEQ memory stage. It sits between execute and write_back. It takes the executed instruction (icode, rA, rB, valA, valE, valP) and performs any data-memory read or write over a req/ack bus. It then hands icode, rA, rB, valE, valM and stat to write_back through a valid/ready handshake. The block is sticky-halting: after a non-AOK status it accepts nothing more until reset.

---
 rtl/y86_pkg.sv | 31 +++
 rtl/mem_op_decode.sv | 69 ++++++
 rtl/memory_stage.sv | 205 ++++++++++++++++++++
 tb/tb_memory_stage.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants: icodes, status encoding, widths, FSM states
package y86_pkg;

  localparam int WORD_W = 64;
  localparam int REG_W  = 4;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] CMOVXX = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_op_decode.sv
// rtl/mem_op_decode.sv - combinational memory-operation decode for the memory stage
//
// Purpose: classify an icode as read / write / no access, pick address and
// store data, and flag 8-byte accesses that fall outside the data memory.
// Ports:
//   icode      in   instruction code
//   valA       in   register A value (store data or pop/ret address)
//   valE       in   ALU result (address for most accesses)
//   valP       in   next PC (store data for call)
//   is_mem     out  instruction touches data memory
//   is_write   out  access is a store
//   addr       out  byte address of the access
//   wdata      out  store data
//   addr_fault out  access would run past MEM_BYTES (or wrap)
module mem_op_decode
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 8192
) (
  input  logic [3:0]        icode,
  input  logic [WORD_W-1:0] valA,
  input  logic [WORD_W-1:0] valE,
  input  logic [WORD_W-1:0] valP,
  output logic              is_mem,
  output logic              is_write,
  output logic [WORD_W-1:0] addr,
  output logic [WORD_W-1:0] wdata,
  output logic              addr_fault
);

  localparam logic [WORD_W:0] LIMIT = (WORD_W+1)'(MEM_BYTES);

  logic [WORD_W:0] end_addr;

  always_comb begin
    is_mem   = 1'b0;
    is_write = 1'b0;
    addr     = '0;
    wdata    = '0;
    case (icode)
      RMMOVQ, PUSHQ: begin
        is_mem   = 1'b1;
        is_write = 1'b1;
        addr     = valE;
        wdata    = valA;
      end
      CALL: begin
        is_mem   = 1'b1;
        is_write = 1'b1;
        addr     = valE;
        wdata    = valP;
      end
      MRMOVQ: begin
        is_mem = 1'b1;
        addr   = valE;
      end
      RET, POPQ: begin
        is_mem = 1'b1;
        addr   = valA;
      end
      default: ;
    endcase
  end

  // One extra bit so addresses near 2^64 cannot wrap back into range.
  assign end_addr   = {1'b0, addr} + (WORD_W+1)'(8);
  assign addr_fault = is_mem && (end_addr > LIMIT);

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 SEQ memory stage with req/ack data bus and valid/ready output
//
// Purpose: accept one executed instruction, perform its data-memory access
// (if any), and present the result to write_back. Halts permanently after
// delivering any non-AOK status until reset.
// Optional build macro: MEM_TIMEOUT_EN - abort a request with ADR when no
//   mem_ack arrives within TIMEOUT_CYCLES cycles.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready             upstream handshake
//   icode rA rB valA valE valP    executed instruction fields
//   instr_valid                   0 = illegal instruction from fetch
//   out_valid/out_ready           downstream handshake
//   out_icode out_rA out_rB       registered instruction fields
//   out_valE out_valM out_stat    registered results and status
//   mem_req mem_we mem_addr mem_wdata   data-memory request
//   mem_ack mem_rdata mem_err     data-memory response
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 8192
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [REG_W-1:0]  rA,
  input  logic [REG_W-1:0]  rB,
  input  logic [WORD_W-1:0] valA,
  input  logic [WORD_W-1:0] valE,
  input  logic [WORD_W-1:0] valP,
  input  logic              instr_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [REG_W-1:0]  out_rA,
  output logic [REG_W-1:0]  out_rB,
  output logic [WORD_W-1:0] out_valE,
  output logic [WORD_W-1:0] out_valM,
  output logic [1:0]        out_stat,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_err
);

  mem_state_t state, state_next;

  logic              halted;
  logic              accept;
  logic              go_req;
  logic [1:0]        pre_stat;

  logic              dec_is_mem;
  logic              dec_is_write;
  logic [WORD_W-1:0] dec_addr;
  logic [WORD_W-1:0] dec_wdata;
  logic              dec_addr_fault;

  logic [3:0]        icode_q;
  logic [REG_W-1:0]  rA_q;
  logic [REG_W-1:0]  rB_q;
  logic [WORD_W-1:0] valE_q;
  logic [WORD_W-1:0] valM_q;
  logic [1:0]        stat_q;
  logic              we_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  logic       timed_out;
  assign timed_out = (state == REQ) && !mem_ack && (wait_cnt == TIMEOUT_LAST);
`endif

  mem_op_decode #(
    .MEM_BYTES (MEM_BYTES)
  ) u_decode (
    .icode      (icode),
    .valA       (valA),
    .valE       (valE),
    .valP       (valP),
    .is_mem     (dec_is_mem),
    .is_write   (dec_is_write),
    .addr       (dec_addr),
    .wdata      (dec_wdata),
    .addr_fault (dec_addr_fault)
  );

  // Status known before any bus traffic; ordering gives INS > HLT > ADR.
  always_comb begin
    pre_stat = STAT_AOK;
    if (!instr_valid)          pre_stat = STAT_INS;
    else if (icode == HALT)    pre_stat = STAT_HLT;
    else if (dec_addr_fault)   pre_stat = STAT_ADR;
  end

  assign accept = in_valid && in_ready;
  assign go_req = dec_is_mem && (pre_stat == STAT_AOK);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = go_req ? REQ : DONE;
      REQ: begin
        if (mem_ack) state_next = DONE;
`ifdef MEM_TIMEOUT_EN
        else if (timed_out) state_next = DONE;
`endif
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; in_ready is forced low while reset is held.
  always_comb begin
    in_ready  = rst_n && (state == IDLE) && !halted;
    out_valid = (state == DONE);
    mem_req   = (state == REQ);
    mem_we    = mem_req && we_q;
    mem_addr  = mem_req ? addr_q  : '0;
    mem_wdata = mem_req ? wdata_q : '0;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icode_q <= '0;
      rA_q    <= '0;
      rB_q    <= '0;
      valE_q  <= '0;
      valM_q  <= '0;
      stat_q  <= STAT_AOK;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      halted  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            icode_q <= icode;
            rA_q    <= rA;
            rB_q    <= rB;
            valE_q  <= valE;
            valM_q  <= '0;
            stat_q  <= pre_stat;
            we_q    <= dec_is_write;
            addr_q  <= dec_addr;
            wdata_q <= dec_wdata;
          end
        end
        REQ: begin
          if (mem_ack) begin
            valM_q <= (mem_err || we_q) ? '0 : mem_rdata;
            stat_q <= mem_err ? STAT_ADR : STAT_AOK;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timed_out) begin
            valM_q <= '0;
            stat_q <= STAT_ADR;
          end
`endif
        end
        DONE: begin
          if (out_ready && (stat_q != STAT_AOK)) halted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wait_cnt <= '0;
    else if (state == REQ)   wait_cnt <= wait_cnt + 8'd1;
    else                     wait_cnt <= '0;
  end
`endif

  assign out_icode = icode_q;
  assign out_rA    = rA_q;
  assign out_rB    = rB_q;
  assign out_valE  = valE_q;
  assign out_valM  = valM_q;
  assign out_stat  = stat_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard testbench for memory_stage
module tb_memory_stage;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valA;
  logic [63:0] valE;
  logic [63:0] valP;
  logic        instr_valid;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_icode;
  logic [3:0]  out_rA;
  logic [3:0]  out_rB;
  logic [63:0] out_valE;
  logic [63:0] out_valM;
  logic [1:0]  out_stat;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        mem_err;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [1:0]  stat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mexp_t;

  exp_t  exp_q[$];
  mexp_t mexp_q[$];

  int          total = 0;
  int          bad = 0;
  int          ack_delay = 1;
  logic [63:0] ack_rdata = '0;
  logic        ack_err = 1'b0;

  memory_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .icode      (icode),
    .rA         (rA),
    .rB         (rB),
    .valA       (valA),
    .valE       (valE),
    .valP       (valP),
    .instr_valid(instr_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_icode  (out_icode),
    .out_rA     (out_rA),
    .out_rB     (out_rB),
    .out_valE   (out_valE),
    .out_valM   (out_valM),
    .out_stat   (out_stat),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_icode", out_icode, e.icode);
          chk("out_rA", out_rA, e.rA);
          chk("out_rB", out_rB, e.rB);
          chk("out_valE", out_valE, e.valE);
          chk("out_valM", out_valM, e.valM);
          chk("out_stat", out_stat, e.stat);
        end
      end
    end
  end

  // Memory responder: checks each request, acks after ack_delay cycles (0 = never).
  initial begin
    mexp_t m;
    mem_ack = 1'b0;
    mem_rdata = '0;
    mem_err = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (mexp_q.size() == 0) begin
          chk("unexpected_mem_req", 64'd1, 64'd0);
        end else begin
          m = mexp_q.pop_front();
          chk("mem_we", mem_we, m.we);
          chk("mem_addr", mem_addr, m.addr);
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
        end
        for (int c = 1; c < 1000; c++) begin
          if (!mem_req) break;
          if (ack_delay != 0 && c == ack_delay) begin
            mem_ack = 1'b1;
            mem_rdata = ack_rdata;
            mem_err = ack_err;
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = '0;
            mem_err = 1'b0;
            break;
          end
          @(negedge clk);
          if (mem_req) chk("mem_addr_stable", mem_addr, m.addr);
        end
      end
    end
  end

  task automatic expect_mem(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    mexp_t m;
    m.we = we;
    m.addr = addr;
    m.wdata = wdata;
    mexp_q.push_back(m);
  endtask

  task automatic issue(input string nm, input logic [3:0] ic, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] va, input logic [63:0] ve,
                       input logic [63:0] vp, input logic iv, input logic [63:0] xm,
                       input logic [1:0] xs, input int lat, input int hold);
    exp_t e;
    int cnt;
    e.icode = ic; e.rA = ra; e.rB = rb; e.valE = ve; e.valM = xm; e.stat = xs;
    exp_q.push_back(e);
    @(posedge clk); #1;
    icode = ic; rA = ra; rB = rb; valA = va; valE = ve; valP = vp; instr_valid = iv;
    in_valid = 1'b1;
    if (hold > 0) out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    instr_valid = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < lat + 20);
    chk({nm, "_latency"}, cnt, lat);
    for (int h = 0; h < hold; h++) begin
      if (h > 0) @(negedge clk);
      chk({nm, "_hold_valid"}, out_valid, 1);
      chk({nm, "_hold_valE"}, out_valE, e.valE);
      chk({nm, "_hold_valM"}, out_valM, e.valM);
      chk({nm, "_hold_stat"}, out_stat, e.stat);
      chk({nm, "_hold_no_req"}, mem_req, 0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    cnt = 0;
    while (out_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk({nm, "_drained"}, out_valid, 0);
  endtask

  task automatic check_halted(input string nm);
    @(posedge clk); #1;
    icode = IRMOVQ; rA = 4'hF; rB = 4'h1; valE = 64'h5; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({nm, "_halt_in_ready"}, in_ready, 0);
      chk({nm, "_halt_out_valid"}, out_valid, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_in_ready", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    icode = '0; rA = '0; rB = '0;
    valA = '0; valE = '0; valP = '0;
    instr_valid = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_out_stat", out_stat, 0);
    chk("reset_out_valM", out_valM, 0);
    chk("reset_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rel_in_ready", in_ready, 1);

    issue("irmovq", IRMOVQ, 4'hF, 4'h2, 64'h0, 64'h10, 64'h0, 1'b1, 64'h0, STAT_AOK, 1, 0);

    ack_delay = 3; ack_rdata = 64'hDEAD_BEEF; ack_err = 1'b0;
    expect_mem(1'b0, 64'h100, 64'h0);
    issue("mrmovq", MRMOVQ, 4'h1, 4'h4, 64'h0, 64'h100, 64'h0, 1'b1, 64'hDEAD_BEEF, STAT_AOK, 4, 0);

    ack_delay = 1; ack_rdata = 64'h0;
    expect_mem(1'b1, 64'h1F8, 64'h55);
    issue("pushq", PUSHQ, 4'h3, 4'hF, 64'h55, 64'h1F8, 64'h0, 1'b1, 64'h0, STAT_AOK, 2, 4);

    ack_delay = 2;
    expect_mem(1'b1, 64'h200, 64'h1234);
    issue("call", CALL, 4'hF, 4'h4, 64'h999, 64'h200, 64'h1234, 1'b1, 64'h0, STAT_AOK, 3, 0);

    ack_delay = 1; ack_rdata = 64'h77;
    expect_mem(1'b0, 64'h300, 64'h0);
    issue("popq", POPQ, 4'h6, 4'h4, 64'h300, 64'h308, 64'h0, 1'b1, 64'h77, STAT_AOK, 2, 0);

    ack_rdata = 64'hABC;
    expect_mem(1'b0, 64'h1FF8, 64'h0);
    issue("ret_top", RET, 4'hF, 4'h4, 64'h1FF8, 64'h2000, 64'h0, 1'b1, 64'hABC, STAT_AOK, 2, 0);

    ack_rdata = 64'h0;
    expect_mem(1'b1, 64'd8184, 64'h42);
    issue("rmmovq_edge", RMMOVQ, 4'h2, 4'h3, 64'h42, 64'd8184, 64'h0, 1'b1, 64'h0, STAT_AOK, 2, 0);

    ack_delay = 2; ack_rdata = 64'h1111; ack_err = 1'b1;
    expect_mem(1'b0, 64'h40, 64'h0);
    issue("bus_err", MRMOVQ, 4'h1, 4'h2, 64'h0, 64'h40, 64'h0, 1'b1, 64'h0, STAT_ADR, 3, 0);
    ack_err = 1'b0;
    check_halted("bus_err");
    do_reset();

    issue("rmmovq_oob", RMMOVQ, 4'h2, 4'h3, 64'h9, 64'd8190, 64'h0, 1'b1, 64'h0, STAT_ADR, 1, 0);
    check_halted("rmmovq_oob");
    do_reset();

    issue("wrap", MRMOVQ, 4'h1, 4'h2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b1, 64'h0, STAT_ADR, 1, 0);
    do_reset();

    issue("halt", HALT, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 1'b1, 64'h0, STAT_HLT, 1, 0);
    check_halted("halt");
    do_reset();

    issue("ins", MRMOVQ, 4'h1, 4'h2, 64'h0, 64'h100, 64'h0, 1'b0, 64'h0, STAT_INS, 1, 0);
    check_halted("ins");
    do_reset();

    ack_delay = 0;
    expect_mem(1'b0, 64'h80, 64'h0);
    @(posedge clk); #1;
    icode = MRMOVQ; rA = 4'h1; rB = 4'h2; valA = '0; valE = 64'h80; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreq_mem_req", mem_req, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreq_rst_mem_req", mem_req, 0);
    chk("midreq_rst_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack_delay = 1;
    issue("after_rst", IRMOVQ, 4'hF, 4'h5, 64'h0, 64'h20, 64'h0, 1'b1, 64'h0, STAT_AOK, 1, 0);

`ifdef MEM_TIMEOUT_EN
    ack_delay = 0;
    expect_mem(1'b0, 64'h500, 64'h0);
    issue("timeout", MRMOVQ, 4'h1, 4'h2, 64'h0, 64'h500, 64'h0, 1'b1, 64'h0, STAT_ADR, 256, 0);
    ack_delay = 1;
    do_reset();
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("mem_expect_empty", mexp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
